// File: rtl/aes_mask_ctrl.sv
// aes_mask_ctrl: job sequencer in front of the aes_mask core.
// Accepts a key/block job, issues init / R x next / finalize to the core,
// then captures the core result into a held mask with a one-cycle strobe.
// Every output is a flop; the core strobes and ready are decoded from the
// next state so they line up with the state they belong to.
module aes_mask_ctrl #(
  parameter int ROUNDS_128 = 10,
  parameter int ROUNDS_256 = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic         ready,
  output logic [127:0] mask,
  output logic         mask_valid,
  output logic         core_init,
  output logic         core_next,
  output logic         core_finalize,
  output logic [127:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic [127:0] core_result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_NEXT    = 3'd2,
    S_FINAL   = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  localparam logic [4:0] LAST_128 = 5'(ROUNDS_128 - 1);
  localparam logic [4:0] LAST_256 = 5'(ROUNDS_256 - 1);

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] block_q, block_d;
  logic         keylen_q, keylen_d;
  logic [127:0] mask_q, mask_d;
  logic         mask_valid_q, mask_valid_d;
  logic         ready_q, ready_d;
  logic         init_q, init_d;
  logic         next_q, next_d;
  logic         fin_q, fin_d;
  logic [4:0]   last_s;

  // Terminal round count follows the key length captured at accept.
  assign last_s = keylen_q ? LAST_256 : LAST_128;

  // Next-state, operand capture and output decodes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    block_d      = block_q;
    keylen_d     = keylen_q;
    mask_d       = mask_q;
    mask_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d  = S_INIT;
          key_d    = key;
          block_d  = block;
          keylen_d = keylen;
          cnt_d    = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_NEXT;
      end
      S_NEXT: begin
        cnt_d = cnt_q + 5'd1;
        if (abort)                state_d = S_IDLE;
        else if (cnt_q == last_s) state_d = S_FINAL;
        else                      state_d = S_NEXT;
      end
      S_FINAL: begin
        if (abort) state_d = S_IDLE;
        else       state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (!abort) begin
          mask_d       = core_result;
          mask_valid_d = 1'b1;
        end else begin
          mask_d = mask_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    init_d  = (state_d == S_INIT);
    next_d  = (state_d == S_NEXT);
    fin_d   = (state_d == S_FINAL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      key_q        <= 128'd0;
      block_q      <= 128'd0;
      keylen_q     <= 1'b0;
      mask_q       <= 128'd0;
      mask_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      init_q       <= 1'b0;
      next_q       <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      block_q      <= block_d;
      keylen_q     <= keylen_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
      ready_q      <= ready_d;
      init_q       <= init_d;
      next_q       <= next_d;
      fin_q        <= fin_d;
    end
  end

  assign ready         = ready_q;
  assign mask          = mask_q;
  assign mask_valid    = mask_valid_q;
  assign core_init     = init_q;
  assign core_next     = next_q;
  assign core_finalize = fin_q;
  assign core_key      = key_q;
  assign core_keylen   = keylen_q;
  assign core_block    = block_q;

endmodule

// File: tb/tb_aes_mask_ctrl.sv
// Bench for aes_mask_ctrl: a behavioural aes_mask core answers the strobes,
// a job-level reference model predicts strobes, ready, operands and masks,
// and a negedge monitor compares against a scoreboard queue.
module tb_aes_mask_ctrl;

  localparam int R128 = 10;
  localparam int R256 = 14;
  localparam int NEVER = 32'h7fffffff;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key = 128'd0;
  logic         keylen = 1'b0;
  logic [127:0] block = 128'd0;
  logic         ready, mask_valid, core_init, core_next, core_finalize, core_keylen;
  logic [127:0] mask, core_key, core_block, core_result;

  aes_mask_ctrl #(.ROUNDS_128(R128), .ROUNDS_256(R256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .key(key), .keylen(keylen), .block(block), .ready(ready),
    .mask(mask), .mask_valid(mask_valid), .core_init(core_init),
    .core_next(core_next), .core_finalize(core_finalize),
    .core_key(core_key), .core_keylen(core_keylen), .core_block(core_block),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Behavioural aes_mask core driven by the DUT strobes.
  logic [127:0] c_st = 128'd0, c_rk = 128'd0;
  always @(posedge clk) begin
    if (!reset_n) begin
      c_st <= 128'd0; c_rk <= 128'd0;
    end else if (core_init) begin
      c_st <= core_block; c_rk <= core_key;
    end else if (core_next) begin
      c_rk <= {c_rk[21:0], c_rk[127:22]};
      c_st <= c_st ^ {c_rk[21:0], c_rk[127:22]};
    end else if (core_finalize) begin
      c_st <= c_st ^ core_block ^ c_rk ^ core_key;
      c_rk <= c_rk ^ core_key;
    end
  end
  assign core_result = c_st;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference mask for a whole job, straight from the round rules.
  function automatic logic [127:0] ref_mask(input logic [127:0] k, input logic [127:0] b, input int r);
    logic [127:0] st, rk;
    st = b; rk = k;
    for (int i = 0; i < r; i++) begin
      rk = {rk[21:0], rk[127:22]};
      st = st ^ rk;
    end
    return st ^ b ^ rk ^ k;
  endfunction

  typedef struct { logic [127:0] m; int due; } exp_t;
  exp_t q[$];

  // Job-level model state
  bit           job_live = 1'b0;
  int           ja = 0, jr = 0, ab_cyc = NEVER;
  logic [127:0] jkey = 128'd0, jblk = 128'd0, pkey = 128'd0, pblk = 128'd0;
  logic         jkl = 1'b0, pkl = 1'b0;
  logic [127:0] held = 128'd0;
  bit           chk_en = 1'b0, done = 1'b0, final_done = 1'b0;
  int           total = 0, bad = 0;

  function automatic bit active_at(input int c);
    return job_live && c > ja && c <= ja + jr + 3 && c <= ab_cyc;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      bit act, due;
      exp_t it;
      act = active_at(cyc);
      d = cyc - ja;
      chk("ready", {127'd0, ready}, {127'd0, !act});
      chk("core_init", {127'd0, core_init}, {127'd0, act && d == 1});
      chk("core_next", {127'd0, core_next}, {127'd0, act && d >= 2 && d <= jr + 1});
      chk("core_finalize", {127'd0, core_finalize}, {127'd0, act && d == jr + 2});
      chk("core_key", core_key, (job_live && cyc > ja) ? jkey : pkey);
      chk("core_block", core_block, (job_live && cyc > ja) ? jblk : pblk);
      chk("core_keylen", {127'd0, core_keylen}, {127'd0, (job_live && cyc > ja) ? jkl : pkl});
      due = (q.size() > 0) && (q[0].due == cyc);
      chk("mask_valid", {127'd0, mask_valid}, {127'd0, due});
      if (mask_valid && q.size() > 0) begin
        it = q.pop_front();
        held = it.m;
      end
      chk("mask", mask, held);
      if (done && !final_done) begin
        chk("queue_empty", 128'(q.size()), 128'd0);
        final_done = 1'b1;
      end
    end
  end

  // Advance one cycle, updating the model with what is driven this cycle.
  task automatic step();
    if (abort) begin
      if (active_at(cyc)) begin
        ab_cyc = cyc;
        void'(q.pop_back());
      end
    end else if (start && !active_at(cyc)) begin
      pkey = job_live ? jkey : pkey;
      pblk = job_live ? jblk : pblk;
      pkl  = job_live ? jkl : pkl;
      job_live = 1'b1;
      ja = cyc; jr = keylen ? R256 : R128; ab_cyc = NEVER;
      jkey = key; jblk = block; jkl = keylen;
      q.push_back('{ref_mask(key, block, jr), cyc + jr + 4});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    q.delete();
    job_live = 1'b0; ab_cyc = NEVER;
    jkey = 128'd0; jblk = 128'd0; jkl = 1'b0;
    pkey = 128'd0; pblk = 128'd0; pkl = 1'b0;
    held = 128'd0;
    chk_en = 1'b1;
  endtask

  task automatic go(input logic [127:0] k, input logic [127:0] b, input logic kl);
    key = k; block = b; keylen = kl; start = 1'b1; abort = 1'b0;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1;
    apply_reset();
    // reset state held while idle
    idle(5);
    // all-zero AES-128 job
    go(128'd0, 128'd0, 1'b0);
    idle(16);
    // AES-256 job with a known key
    go(128'h0123456789abcdef0123456789abcdef, 128'd0, 1'b1);
    idle(20);
    // operands change and start repeats in cycle 2: ignored
    go(128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'hdead_beef_0000_0000_0000_0000_cafe_f00d, 1'b0);
    step();
    key = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
    block = 128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f;
    keylen = 1'b1; start = 1'b1;
    step();
    idle(16);
    // abort in cycle 6 of an AES-128 job
    go(128'h0badc0de_12345678_9abcdef0_55aa55aa, 128'h77, 1'b0);
    idle(5);
    abort = 1'b1;
    step();
    idle(16);
    // back-to-back: second start in the first mask_valid cycle
    go(128'haaaa_5555_aaaa_5555_aaaa_5555_aaaa_5555, 128'h1234, 1'b0);
    idle(13);
    go(128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa, 128'h4321, 1'b0);
    idle(16);
    // randomized jobs with spurious starts, operand churn and aborts
    for (int j = 0; j < 40; j++) begin
      int r, ab_at;
      logic kl;
      bit aborted;
      kl = 1'($urandom_range(0, 1));
      r = kl ? R256 : R128;
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r + 3) : 0;
      aborted = 1'b0;
      go({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, kl);
      for (int d = 1; d <= r + 3 && !aborted; d++) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        block = {$urandom, $urandom, $urandom, $urandom};
        keylen = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 4) == 0);
        abort = 1'b0;
        if (d == ab_at) begin
          abort = 1'b1; start = 1'b0; aborted = 1'b1;
        end
        step();
      end
      idle($urandom_range(0, 3));
    end
    // reset in the middle of a job
    go(128'hfeed_face_0000_1111_2222_3333_4444_5555, 128'h99, 1'b1);
    idle(7);
    apply_reset();
    idle(4);
    // drain outstanding expectations within a bounded window
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    done = 1'b1;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
